// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Optional feature macro used by vga_timing_gen: VGA_TIMING_FRAME_CNT_EN.
package vga_timing_pkg;

  // Coordinate counter width and the largest total it can hold
  localparam int unsigned CntW   = 11;
  localparam int unsigned CntMax = 2047;

  // Default 640x480 @ 60 Hz timing (800x525 total)
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFront  = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBack   = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFront  = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBack   = 33;

  // Phase of one raster axis
  typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, phase FSM and registered sync decode.
// Advances only when en is high; wrap flags the step from the last position back to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DefHActive,
  parameter int unsigned FRONT_LEN  = DefHFront,
  parameter int unsigned SYNC_LEN   = DefHSync,
  parameter int unsigned BACK_LEN   = DefHBack,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [CntW-1:0] count,
  output logic            sync,
  output logic            wrap,
  output logic            nxt_active
);

  localparam int unsigned Total = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  localparam logic [CntW-1:0] LastCnt = CntW'(Total - 1);
  localparam logic [CntW-1:0] FrontAt = CntW'(ACTIVE_LEN);
  localparam logic [CntW-1:0] SyncAt  = CntW'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [CntW-1:0] BackAt  = CntW'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  logic [CntW-1:0] count_q, count_d;
  phase_e          phase_q, phase_d;
  logic            sync_q;

  assign wrap = en && (count_q == LastCnt);

  // Next position and phase; phase is decoded from the position being loaded so that
  // registered phase and sync line up with the registered count.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      unique case (phase_q)
        PhActive: if (count_d == FrontAt) phase_d = PhFront;
        PhFront:  if (count_d == SyncAt)  phase_d = PhSync;
        PhSync:   if (count_d == BackAt)  phase_d = PhBack;
        PhBack:   if (wrap)               phase_d = PhActive;
        default:                          phase_d = PhActive;
      endcase
    end
  end

  // State and registered sync output
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PhActive;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= (phase_d == PhSync) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign count      = count_q;
  assign sync       = sync_q;
  assign nxt_active = (phase_d == PhActive);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, sync pulses, display enable and
// line/frame start strobes, all registered and aligned to the same pixel.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FRONT  = DefVFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [CntW-1:0] pixelx,
  output logic [CntW-1:0] pixely,
  output logic            hsync,
  output logic            vsync,
  output logic            active,
  output logic            line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]     frame_cnt,
`endif
  output logic            frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (HTotal > CntMax || VTotal > CntMax) begin : g_bad_total
    $error("vga_timing_gen: H or V total exceeds 2047");
  end

  logic h_wrap, v_wrap;
  logic h_nxt_active, v_nxt_active;
  logic active_q, line_start_q, frame_start_q;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .count      (pixelx),
    .sync       (hsync),
    .wrap       (h_wrap),
    .nxt_active (h_nxt_active)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (pixely),
    .sync       (vsync),
    .wrap       (v_wrap),
    .nxt_active (v_nxt_active)
  );

  // Strobes and display enable, registered against the coordinates being loaded.
  // v_wrap implies h_wrap, so it marks the step into (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      active_q      <= h_nxt_active && v_nxt_active;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps together with the frame_start it accompanies; reset presents 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
